// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and export-word layout for the dependency checker.
// The flush feature is enabled with the ROB_FLUSH_EN macro.
package rob_pkg;

    localparam int ROB_ID_SIZE          = 3;
    localparam int ROB_REG_ADDRESS_SIZE = 5;
    localparam int ROB_REGISTER_SIZE    = 32;

    // unavailable word: {addr, wr, id, valid}; available prepends value
    localparam int U_VALID_BIT = 0;
    localparam int U_ID_LSB    = 1;
    localparam int U_WR_BIT    = ROB_ID_SIZE + 1;
    localparam int U_ADDR_LSB  = ROB_ID_SIZE + 2;
    localparam int U_WIDTH     = ROB_REG_ADDRESS_SIZE + ROB_ID_SIZE + 2;
    localparam int A_VALUE_LSB = U_WIDTH;
    localparam int A_WIDTH     = U_WIDTH + ROB_REGISTER_SIZE;

    typedef struct packed {
        logic occupied;
        logic done;
    } rob_state_t;

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot: status, destination and result registers,
// plus the two packed export words for the dependency checker.
module rob_entry
    import rob_pkg::*;
#(
    parameter int ID_SIZE          = ROB_ID_SIZE,
    parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int REGISTER_SIZE    = ROB_REGISTER_SIZE,
    parameter int SLOT             = 0
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic                        alloc_en,
    input  logic [REG_ADDRESS_SIZE-1:0] alloc_addr,
    input  logic                        alloc_wr,
    input  logic                        wb_en,
    input  logic [REGISTER_SIZE-1:0]    wb_value,
    input  logic                        commit_en,
    output rob_state_t                  state,
    output logic [REG_ADDRESS_SIZE-1:0] addr,
    output logic                        wr,
    output logic [REGISTER_SIZE-1:0]    value,
    output logic [REG_ADDRESS_SIZE+ID_SIZE+1:0] unavailable,
    output logic [REGISTER_SIZE+REG_ADDRESS_SIZE+ID_SIZE+1:0] available
);

    localparam logic [ID_SIZE-1:0] ID = ID_SIZE'(SLOT);

    // Alloc and commit never hit the same slot in one cycle; a writeback
    // landing on a slot being allocated is dropped since it is not yet occupied.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= '0;
            addr  <= '0;
            wr    <= 1'b0;
            value <= '0;
        end else if (alloc_en) begin
            state <= '{occupied: 1'b1, done: 1'b0};
            addr  <= alloc_addr;
            wr    <= alloc_wr;
            value <= '0;
        end else if (commit_en) begin
            state <= '0;
        end else if (wb_en && state.occupied && !state.done) begin
            state.done <= 1'b1;
            value      <= wb_value;
        end
    end

    assign unavailable = {addr, wr, ID, state.occupied & ~state.done};
    assign available   = {value, addr, wr, ID, state.occupied & state.done};

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer feeding the register-dependency checker.
// Define ROB_FLUSH_EN to add a flush port that clears the buffer like reset.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ID_SIZE          = ROB_ID_SIZE,
    parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int REGISTER_SIZE    = ROB_REGISTER_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef ROB_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        alloc_valid,
    input  logic [REG_ADDRESS_SIZE-1:0] alloc_addr,
    input  logic                        alloc_wr,
    output logic                        alloc_ready,
    output logic [ID_SIZE-1:0]          alloc_id,
    input  logic                        wb_valid,
    input  logic [ID_SIZE-1:0]          wb_id,
    input  logic [REGISTER_SIZE-1:0]    wb_value,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [REG_ADDRESS_SIZE-1:0] commit_addr,
    output logic                        commit_wr,
    output logic [REGISTER_SIZE-1:0]    commit_value,
    output logic [ID_SIZE-1:0]          tail,
    output logic                        full,
    output logic                        empty,
    output logic [(1<<ID_SIZE)-1:0][REG_ADDRESS_SIZE+ID_SIZE+1:0] unavailable,
    output logic [(1<<ID_SIZE)-1:0][REGISTER_SIZE+REG_ADDRESS_SIZE+ID_SIZE+1:0] available
);

    localparam int N = 1 << ID_SIZE;
    localparam logic [ID_SIZE:0] N_CNT = (ID_SIZE+1)'(N);

    logic [ID_SIZE-1:0] head;
    logic [ID_SIZE:0]   count;
    logic               clear;
    logic               alloc_fire;
    logic               commit_fire;

    rob_state_t                  st      [N];
    logic [REG_ADDRESS_SIZE-1:0] e_addr  [N];
    logic                        e_wr    [N];
    logic [REGISTER_SIZE-1:0]    e_value [N];

`ifdef ROB_FLUSH_EN
    assign clear = reset | flush;
`else
    assign clear = reset;
`endif

    assign full         = (count == N_CNT);
    assign empty        = (count == '0);
    assign alloc_ready  = !full;
    assign alloc_id     = tail;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign commit_valid = st[head].occupied && st[head].done;
    assign commit_fire  = commit_valid && commit_ready;
    assign commit_addr  = e_addr[head];
    assign commit_wr    = e_wr[head];
    assign commit_value = e_value[head];

    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire)
                tail <= tail + 1'b1;
            if (commit_fire)
                head <= head + 1'b1;
            unique case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_slot
        rob_entry #(
            .ID_SIZE(ID_SIZE),
            .REG_ADDRESS_SIZE(REG_ADDRESS_SIZE),
            .REGISTER_SIZE(REGISTER_SIZE),
            .SLOT(i)
        ) u_entry (
            .clk(clk),
            .clear(clear),
            .alloc_en(alloc_fire && (tail == ID_SIZE'(i))),
            .alloc_addr(alloc_addr),
            .alloc_wr(alloc_wr),
            .wb_en(wb_valid && (wb_id == ID_SIZE'(i))),
            .wb_value(wb_value),
            .commit_en(commit_fire && (head == ID_SIZE'(i))),
            .state(st[i]),
            .addr(e_addr[i]),
            .wr(e_wr[i]),
            .value(e_value[i]),
            .unavailable(unavailable[i]),
            .available(available[i])
        );
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: commits are checked against allocation order.
// Flush scenario is exercised when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;

    logic              clk = 1'b0;
    logic              reset;
`ifdef ROB_FLUSH_EN
    logic              flush = 1'b0;
`endif
    logic              alloc_valid = 1'b0;
    logic [4:0]        alloc_addr = '0;
    logic              alloc_wr = 1'b0;
    logic              alloc_ready;
    logic [2:0]        alloc_id;
    logic              wb_valid = 1'b0;
    logic [2:0]        wb_id = '0;
    logic [31:0]       wb_value = '0;
    logic              commit_valid;
    logic              commit_ready = 1'b0;
    logic [4:0]        commit_addr;
    logic              commit_wr;
    logic [31:0]       commit_value;
    logic [2:0]        tail;
    logic              full;
    logic              empty;
    logic [7:0][9:0]   unavailable;
    logic [7:0][41:0]  available;

    typedef struct {
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] value;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk),
        .reset(reset),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid),
        .alloc_addr(alloc_addr),
        .alloc_wr(alloc_wr),
        .alloc_ready(alloc_ready),
        .alloc_id(alloc_id),
        .wb_valid(wb_valid),
        .wb_id(wb_id),
        .wb_value(wb_value),
        .commit_valid(commit_valid),
        .commit_ready(commit_ready),
        .commit_addr(commit_addr),
        .commit_wr(commit_wr),
        .commit_value(commit_value),
        .tail(tail),
        .full(full),
        .empty(empty),
        .unavailable(unavailable),
        .available(available)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_valid();
        logic v = 1'b0;
        for (int i = 0; i < 8; i++)
            v = v | unavailable[i][0] | available[i][0];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] a, input logic w,
                         input logic [31:0] v, input logic [2:0] exp_id);
        chk("alloc_ready", alloc_ready, 1);
        chk("alloc_id", alloc_id, exp_id);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        alloc_wr    = w;
        sbq.push_back('{addr: a, wr: w, value: v});
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic wb(input logic [2:0] id, input logic [31:0] v);
        wb_valid = 1'b1;
        wb_id    = id;
        wb_value = v;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic drain();
        commit_ready = 1'b1;
        for (int k = 0; k < 20 && !empty; k++)
            tick();
        commit_ready = 1'b0;
        chk("drain_empty", empty, 1);
    endtask

    // Commit monitor: every accepted commit must match the oldest allocation.
    always @(negedge clk) begin
        if (commit_valid && commit_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL commit_unexpected: got addr %0d value %0h expected none",
                         commit_addr, commit_value);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if ({commit_addr, commit_wr, commit_value} !== {e.addr, e.wr, e.value}) begin
                    failures++;
                    $display("FAIL commit: got %0d/%0b/%0h expected %0d/%0b/%0h",
                             commit_addr, commit_wr, commit_value,
                             e.addr, e.wr, e.value);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_tail", tail, 0);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_value", commit_value, 0);
        chk("rst_valids", any_valid(), 0);

        alloc(5'd1, 1'b1, 32'h11111111, 3'd0);
        alloc(5'd2, 1'b1, 32'hDEADBEEF, 3'd1);
        alloc(5'd3, 1'b1, 32'h33333333, 3'd2);
        chk("tail_3", tail, 3);
        for (int k = 0; k < 3; k++)
            chk("unavail_k", unavailable[k], {5'(k + 1), 1'b1, 3'(k), 1'b1});

        wb(3'd1, 32'hDEADBEEF);
        chk("avail_1", available[1], {32'hDEADBEEF, 5'd2, 1'b1, 3'd1, 1'b1});
        chk("unavail_1_v", unavailable[1][0], 0);
        chk("no_commit_head_pending", commit_valid, 0);

        alloc(5'd4, 1'b1, 32'h44444444, 3'd3);
        alloc(5'd5, 1'b0, 32'h55555555, 3'd4);
        alloc(5'd6, 1'b1, 32'h66666666, 3'd5);
        alloc(5'd7, 1'b1, 32'h77777777, 3'd6);
        alloc(5'd8, 1'b1, 32'h88888888, 3'd7);
        chk("full_8", full, 1);
        chk("full_ready", alloc_ready, 0);
        chk("full_tail", tail, 0);

        wb_valid = 1'b1;
        wb_id    = 3'd0;
        wb_value = 32'h11111111;
        #1;
        chk("wb_head_same_cycle", commit_valid, 0);
        tick();
        wb_valid = 1'b0;
        chk("wb_head_next_cycle", commit_valid, 1);

        // Commit while full: the concurrent allocation must be refused.
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        alloc_addr   = 5'd9;
        alloc_wr     = 1'b1;
        tick();
        commit_ready = 1'b0;
        alloc_valid  = 1'b0;
        chk("refused_full", full, 0);
        chk("refused_tail", tail, 0);
        chk("refused_empty", empty, 0);
        chk("slot0_freed", {unavailable[0][0], available[0][0]}, 0);

        alloc(5'd10, 1'b1, 32'h0000000A, 3'd0);
        chk("count7_refill_full", full, 1);

        wb(3'd2, 32'h33333333);
        wb(3'd3, 32'h44444444);
        wb(3'd4, 32'h55555555);
        wb(3'd5, 32'h66666666);
        wb(3'd6, 32'h77777777);
        wb(3'd7, 32'h88888888);
        wb(3'd0, 32'h0000000A);
        drain();
        chk("wrap_tail", tail, 1);

        alloc(5'd11, 1'b1, 32'hAAAA0001, 3'd1);
        alloc(5'd12, 1'b0, 32'h12345678, 3'd2);
        chk("tail_3b", tail, 3);
        wb(3'd5, 32'h00000BAD);
        chk("freed_wb_avail", available[5][0], 0);
        chk("freed_wb_unavail", unavailable[5][0], 0);
        wb(3'd1, 32'hAAAA0001);
        wb(3'd1, 32'hFFFFFFFF);
        chk("done_wb_ignored", available[1][41:10], 32'hAAAA0001);
        wb(3'd2, 32'h12345678);
        drain();

        alloc(5'd13, 1'b1, 32'h0, 3'd3);
        alloc(5'd14, 1'b1, 32'h0, 3'd4);
        reset       = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd15;
        tick();
        reset       = 1'b0;
        alloc_valid = 1'b0;
        sbq.delete();
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_tail", tail, 0);
        chk("mid_rst_valids", any_valid(), 0);

`ifdef ROB_FLUSH_EN
        alloc(5'd16, 1'b1, 32'h0, 3'd0);
        alloc(5'd17, 1'b1, 32'h0, 3'd1);
        alloc(5'd18, 1'b1, 32'h0, 3'd2);
        alloc(5'd19, 1'b1, 32'h0, 3'd3);
        wb(3'd2, 32'h5);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd20;
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        sbq.delete();
        chk("flush_empty", empty, 1);
        chk("flush_tail", tail, 0);
        chk("flush_valids", any_valid(), 0);
`endif

        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
